bin2bcd: RTL and testbench
==========================

# bin2bcd

Converts an 8-bit unsigned binary value into a 3-digit packed BCD value (hundreds, tens, units) using the shift-and-add-3 (double-dabble) algorithm. The output is registered. It sits between a binary datapath (counters, ADC codes, status values) and decimal display/formatting logic. The input is sampled every clock; there is no request/acknowledge handshake.

## Interface
- Parameters: none. Widths are fixed at 8-bit binary in and 12-bit BCD out.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- bin  input  8  unsigned binary operand, 0..255; sampled every cycle.
- bcd  output  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] units; registered.
- out_valid  output  1  high when bcd reflects a sampled bin value, i.e. the pipeline has filled since reset.

## Operation
- Double-dabble on a 20-bit scratch word {12'b0, bin}:
  - 8 iterations.
  - Each iteration: for every BCD nibble ≥5, add 3 to that nibble, then shift the whole word left by 1.
  - After iteration 8, scratch[19:8] is the result.
- Implementation is a fully unrolled combinational add-3 network, not a multi-cycle sequential shifter. Only the nibbles that can reach ≥5 at a given step need correction cells.
- Hundreds digit is only ever 0, 1 or 2; bcd[11:10] is never 2'b11.
- Every legal input maps to a legal BCD result; no overflow case exists (max 255 → 0x255).
- Result is a pure function of bin; no state other than the pipeline registers.
- Reset:
  - bcd = 12'h000
  - out_valid = 0
  - internal pipeline registers = 0
- Reset mid-operation: any in-flight value is discarded. The first bin sampled after rst_n returns high produces the next valid output.

## Timing
- Without BIN2BCD_PIPE_EN: latency 1 cycle.
  - bin sampled at edge N appears on bcd after edge N.
  - out_valid rises after the first edge with rst_n=1.
- With BIN2BCD_PIPE_EN: latency 2 cycles. out_valid rises after the second consecutive edge with rst_n=1.
- Throughput: one conversion per cycle in both modes. Back-to-back changes of bin produce back-to-back results in order.
- bin changes between edges have no effect until the next edge. The output never glitches (registered).
- While rst_n=0, outputs hold their reset values regardless of bin.

## Configuration
- BIN2BCD_PIPE_EN:
  - Defined: adds a register stage after the 4th shift/add-3 iteration, splitting the network in half. Latency becomes 2 cycles, giving higher Fmax. The extra stage resets to 0 and feeds the out_valid delay chain.
  - Undefined: single output register, latency 1.
- Functional results are identical in both modes apart from latency.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with bin=8'd200 → bcd=12'h000, out_valid=0 throughout. Release → out_valid=1 after latency, bcd=12'h200.
- Powers of two: bin = 0, 1, 2, 4, 8, 16, 32, 64, 128, each held for 2 cycles → bcd = 12'h000, 001, 002, 004, 008, 016, 032, 064, 128 after latency.
- Boundaries: bin = 9, 10, 99, 100, 199, 255 → bcd = 12'h009, 010, 099, 100, 199, 255.
- Back-to-back: change bin every cycle through 37, 250, 5, 180 → bcd shows 12'h037, 250, 005, 180 on consecutive cycles at the configured latency.
- Exhaustive: sweep bin 0..255 → each nibble ≤9, bcd[11:10]≠2'b11, and 100·H + 10·T + U == bin. Run with and without BIN2BCD_PIPE_EN.
- Mid-stream reset: assert rst_n=0 for 1 cycle during the sweep → bcd=12'h000 and out_valid=0 on the next cycle. Correct results resume after latency.

Source files
------------

// File: rtl/bin2bcd.sv
// bin2bcd: registered 8-bit binary to 3-digit packed BCD via an unrolled double-dabble network.
// Define BIN2BCD_PIPE_EN to register the network halfway through (latency 2 instead of 1).
module bin2bcd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        out_valid
);
    function automatic logic [19:0] dabble(input logic [19:0] w);
        logic [19:0] t;
        t = w;
        for (int k = 0; k < 3; k++)
            t[8+4*k +: 4] = (t[8+4*k +: 4] >= 4'd5) ? t[8+4*k +: 4] + 4'd3 : t[8+4*k +: 4];
        return {t[18:0], 1'b0};
    endfunction
    function automatic logic [11:0] dabble_hi(input logic [19:0] w);
        logic [19:0] t;
        t = dabble(w);
        return t[19:8];
    endfunction
    logic [19:0] s1, s2, s3, s4, s4_src, s5, s6, s7;
    assign s1 = dabble({12'b0, bin});
    assign s2 = dabble(s1);
    assign s3 = dabble(s2);
    assign s4 = dabble(s3);
    assign s5 = dabble(s4_src);
    assign s6 = dabble(s5);
    assign s7 = dabble(s6);
`ifdef BIN2BCD_PIPE_EN
    logic [19:0] mid;
    logic        mid_v;
    assign s4_src = mid;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mid       <= '0;
            mid_v     <= 1'b0;
            bcd       <= '0;
            out_valid <= 1'b0;
        end else begin
            mid       <= s4;
            mid_v     <= 1'b1;
            bcd       <= dabble_hi(s7);
            out_valid <= mid_v;
        end
    end
`else
    assign s4_src = s4;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd       <= '0;
            out_valid <= 1'b0;
        end else begin
            bcd       <= dabble_hi(s7);
            out_valid <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bin2bcd.sv
// tb_bin2bcd: directed plus random stimulus checked against an arithmetic decimal model.
module tb_bin2bcd;
`ifdef BIN2BCD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic        clk;
    logic        rst_n;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        out_valid;
    int          errs;
    int          checks;
    logic        mv [0:1];
    logic [7:0]  mb [0:1];

    bin2bcd dut (.clk(clk), .rst_n(rst_n), .bin(bin), .bcd(bcd), .out_valid(out_valid));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input logic [7:0] b);
        return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
    endfunction

    task automatic step(input logic [7:0] b, input logic r);
        logic        ev;
        logic [7:0]  eb;
        logic [11:0] ebcd;
        int          sum;
        @(negedge clk);
        bin   = b;
        rst_n = r;
        @(posedge clk);
        if (!r) begin
            mv[0] = 1'b0; mv[1] = 1'b0; mb[0] = 8'd0; mb[1] = 8'd0;
        end else begin
            mv[1] = mv[0]; mb[1] = mb[0]; mv[0] = 1'b1; mb[0] = b;
        end
        ev   = mv[LAT-1];
        eb   = mb[LAT-1];
        ebcd = ev ? to_bcd(eb) : 12'h000;
        #1;
        checks++;
        assert (out_valid === ev) else begin
            errs++;
            $error("FAIL valid: got %b expected %b (bin=%0d rst_n=%b)", out_valid, ev, b, r);
        end
        checks++;
        assert (bcd === ebcd) else begin
            errs++;
            $error("FAIL bcd: got %h expected %h (bin=%0d rst_n=%b)", bcd, ebcd, b, r);
        end
        if (ev) begin
            sum = 100 * int'(bcd[11:8]) + 10 * int'(bcd[7:4]) + int'(bcd[3:0]);
            checks++;
            assert (bcd[11:10] != 2'b11 && bcd[7:4] <= 4'd9 && bcd[3:0] <= 4'd9 && sum == int'(eb)) else begin
                errs++;
                $error("FAIL legal: got %h (value %0d) expected legal BCD of %0d", bcd, sum, eb);
            end
        end
    endtask

    initial begin
        logic [7:0] pw [0:8];
        logic [7:0] bd [0:5];
        logic [7:0] bb [0:3];
        errs = 0;
        checks = 0;
        rst_n = 1'b0;
        bin = 8'd200;
        mv[0] = 1'b0; mv[1] = 1'b0; mb[0] = 8'd0; mb[1] = 8'd0;
        pw = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128};
        bd = '{8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd255};
        bb = '{8'd37, 8'd250, 8'd5, 8'd180};
        for (int i = 0; i < 3; i++) step(8'd200, 1'b0);
        for (int i = 0; i < 3; i++) step(8'd200, 1'b1);
        foreach (pw[i]) begin step(pw[i], 1'b1); step(pw[i], 1'b1); end
        foreach (bd[i]) begin step(bd[i], 1'b1); step(bd[i], 1'b1); end
        foreach (bb[i]) step(bb[i], 1'b1);
        for (int i = 0; i < 2; i++) step(8'd0, 1'b1);
        for (int i = 0; i < 256; i++) step(8'(i), i != 128);
        for (int i = 0; i < 3; i++) step(8'd255, 1'b1);
        for (int i = 0; i < 300; i++) step(8'($urandom), $urandom_range(0, 19) != 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
